// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch FIFO entry type for the fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = '0;
  localparam int unsigned             PC_STEP   = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
    logic                    fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: head {pc, instr, fault} under valid/ready.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_fault;

  modport master (
    output out_valid, out_instr, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_pc, out_fault,
    output out_ready
  );

endinterface

// File: rtl/imem_sync.sv
// Synchronous-read instruction ROM; out-of-range words read as NOP and flag a fault.
// Contents are preloaded into mem by the environment from the INIT_FILE image.
module imem_sync
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = ADDR_W'(32'h0040_0000),
  parameter int unsigned       MEM_WORDS = 1024,
  parameter string             INIT_FILE = "add_test.v"
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              fault
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              fault_d, fault_q;

  // Unsigned compare also catches addresses below MEM_BASE (they wrap high).
  always_comb begin
    word_idx = (addr - MEM_BASE) >> 2;
    in_range = word_idx < ADDR_W'(MEM_WORDS);
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    if (rd_en) begin
      rdata_d = in_range ? mem[word_idx[IDX_W-1:0]] : DATA_W'(NOP_INSTR);
      fault_d = !in_range;
    end
  end

  always_ff @(posedge clock) begin
    rdata_q <= rdata_d;
    fault_q <= fault_d;
  end

  assign rdata = rdata_q;
  assign fault = fault_q;

endmodule

// File: rtl/fetch_unit.sv
// PC, one-deep read credit and prefetch FIFO feeding decode; redirect flushes everything.
// Optional FETCH_PERF_EN adds bubble_count (ready while nothing valid).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0040_0020),
  parameter logic [ADDR_W-1:0] MEM_BASE     = ADDR_W'(32'h0040_0000),
  parameter int unsigned       MEM_WORDS    = 1024,
  parameter string             INIT_FILE    = "add_test.v",
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_unit_if.master      dec_if,
`ifdef FETCH_PERF_EN
  output logic [31:0]       bubble_count,
`endif
  output logic [31:0]       fetch_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] rsp_pc_d, rsp_pc_q;
  logic              inflight_d, inflight_q;
  fetch_entry_t      fifo_d [FIFO_DEPTH];
  fetch_entry_t      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              out_valid_d, out_valid_q;
  logic [31:0]       fetch_count_d, fetch_count_q;

  logic              issue, push, pop;
  fetch_entry_t      rsp_entry, head;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_fault;

  imem_sync #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_BASE  (MEM_BASE),
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_imem (
    .clock (clock),
    .addr  (pc_q),
    .rd_en (issue),
    .rdata (imem_rdata),
    .fault (imem_fault)
  );

  // Credit: buffered plus in-flight never exceeds the FIFO, so a response always has a slot.
  always_comb begin
    pop   = out_valid_q && dec_if.out_ready;
    issue = !redirect_valid && ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    push  = inflight_q && !redirect_valid;

    rsp_entry.pc    = FETCH_ADDR_W'(rsp_pc_q);
    rsp_entry.instr = FETCH_DATA_W'(imem_rdata);
    rsp_entry.fault = imem_fault;

    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    inflight_d    = inflight_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q + 32'(pop);

    if (redirect_valid) begin
      pc_d       = {redirect_addr[ADDR_W-1:2], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d     = pc_q + ADDR_W'(PC_STEP);
        rsp_pc_d = pc_q;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = rsp_entry;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= '0;
      inflight_q    <= 1'b0;
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      inflight_q    <= inflight_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Head is read straight out of storage; a write never lands on the head while it is valid.
  assign head             = fifo_q[rd_ptr_q];
  assign dec_if.out_valid = out_valid_q;
  assign dec_if.out_pc    = ADDR_W'(head.pc);
  assign dec_if.out_instr = DATA_W'(head.instr);
  assign dec_if.out_fault = head.fault;
  assign fetch_count      = fetch_count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_count_d, bubble_count_q;

  always_comb begin
    bubble_count_d = bubble_count_q + 32'(dec_if.out_ready && !out_valid_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a negedge monitor follows reset/redirect/handshakes
// with an address-stream reference model and checks every accepted instruction.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RV    = 32'h0040_0020;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int unsigned WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] fetch_count;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_count;
`endif

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_if         (dif),
`ifdef FETCH_PERF_EN
    .bubble_count   (bubble_count),
`endif
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  fetch_entry_t exp_q [$];
  logic [31:0]  model_pc = '0;
  int unsigned  hs_cnt = 0;
  int unsigned  bub_cnt = 0;
  bit           armed = 0, zero_chk = 0, rst_chk = 0, hold_chk = 0;
  fetch_entry_t hold_e;

  // Image word k holds k+1; anything outside the window is a faulting nop.
  function automatic fetch_entry_t ref_entry(input logic [31:0] pc);
    fetch_entry_t e;
    logic [31:0]  k;
    k    = (pc - BASE) / 4;
    e.pc = pc;
    if (k < WORDS) begin
      e.instr = k + 32'd1;
      e.fault = 1'b0;
    end else begin
      e.instr = 32'd0;
      e.fault = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    fetch_entry_t got;
    fetch_entry_t e;
    got.pc    = dif.out_pc;
    got.instr = dif.out_instr;
    got.fault = dif.out_fault;
    if (armed) begin
      if (zero_chk) begin
        checks++;
        if (dif.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_valid: out_valid=%b required 0 at %0t", dif.out_valid, $time);
        end
      end
      if (rst_chk) begin
        checks++;
        if (got !== '0) begin
          errors++;
          $display("FAIL reset_outputs: pc=%h instr=%h fault=%b required zeros", got.pc, got.instr, got.fault);
        end
      end
      if (hold_chk) begin
        checks++;
        if (dif.out_valid !== 1'b1 || got !== hold_e) begin
          errors++;
          $display("FAIL stall_hold: valid=%b pc=%h instr=%h required pc=%h instr=%h at %0t",
                   dif.out_valid, got.pc, got.instr, hold_e.pc, hold_e.instr, $time);
        end
      end
      checks++;
      if (fetch_count !== hs_cnt) begin
        errors++;
        $display("FAIL fetch_count: got %0d required %0d at %0t", fetch_count, hs_cnt, $time);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (bubble_count !== bub_cnt) begin
        errors++;
        $display("FAIL bubble_count: got %0d required %0d at %0t", bubble_count, bub_cnt, $time);
      end
`endif
      if (!reset && dif.out_valid === 1'b1 && dif.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL entry: pc=%h accepted with no expectation queued", got.pc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL entry: pc=%h instr=%h fault=%b required pc=%h instr=%h fault=%b at %0t",
                     got.pc, got.instr, got.fault, e.pc, e.instr, e.fault, $time);
          end
        end
      end
    end

    // Advance the model across the coming clock edge.
    zero_chk = 0;
    rst_chk  = 0;
    hold_chk = 0;
    if (reset) begin
      exp_q.delete();
      model_pc = RV;
      hs_cnt   = 0;
      bub_cnt  = 0;
      armed    = 1;
      zero_chk = 1;
      rst_chk  = 1;
    end else if (armed) begin
      if (dif.out_valid && dif.out_ready) hs_cnt++;
      if (dif.out_ready && !dif.out_valid) bub_cnt++;
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_addr & ~32'h3;
        zero_chk = 1;
      end else if (dif.out_valid && !dif.out_ready) begin
        hold_chk = 1;
        hold_e   = got;
      end
    end
    if (armed) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(ref_entry(model_pc));
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (dif.out_valid !== 1'b1 && n < 12);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] a;
    for (int k = 0; k < int'(WORDS); k++) dut.u_imem.mem[k] = 32'(k + 1);
    dif.out_ready = 1'b0;

    // Reset state and first-fetch latency.
    tick(3);
    @(negedge clock);
    chk("reset_valid", 32'(dif.out_valid), 32'd0);
    chk("reset_fetch_count", fetch_count, 32'd0);
    tick(1);
    reset = 1'b0;
    dif.out_ready = 1'b1;
    wait_valid(n);
    chk("first_valid_latency", 32'(n), 32'd3);
    chk("first_pc", dif.out_pc, RV);
    chk("first_instr", dif.out_instr, 32'd9);
    tick(20);

    // Stall from reset: four entries buffered, head holds.
    reset = 1'b1;
    dif.out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("stall_valid", 32'(dif.out_valid), 32'd1);
    chk("stall_head_pc", dif.out_pc, RV);
    chk("stall_head_instr", dif.out_instr, 32'd9);
    dif.out_ready = 1'b1;
    tick(12);

    // Redirect with three entries buffered; handshake in the redirect cycle counts.
    reset = 1'b1;
    dif.out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("pre_redirect_valid", 32'(dif.out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0040_0103;
    dif.out_ready  = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    wait_valid(n);
    chk("redirect_latency", 32'(n), 32'd3);
    chk("redirect_pc", dif.out_pc, 32'h0040_0100);
    chk("redirect_instr", dif.out_instr, 32'd65);
    tick(10);

    // Redirect outside imem.
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0050_0000;
    tick(1);
    redirect_valid = 1'b0;
    wait_valid(n);
    chk("fault_latency", 32'(n), 32'd3);
    chk("fault_pc", dif.out_pc, 32'h0050_0000);
    chk("fault_instr", dif.out_instr, 32'd0);
    chk("fault_flag", 32'(dif.out_fault), 32'd1);
    tick(1);
    chk("fault_next_pc", dif.out_pc, 32'h0050_0004);
    chk("fault_next_flag", 32'(dif.out_fault), 32'd1);
    tick(5);

    // Reset mid-stream with a full FIFO.
    dif.out_ready = 1'b0;
    tick(8);
    reset = 1'b1;
    tick(1);
    chk("midreset_valid", 32'(dif.out_valid), 32'd0);
    chk("midreset_fetch_count", fetch_count, 32'd0);
    reset = 1'b0;
    dif.out_ready = 1'b1;
    wait_valid(n);
    chk("midreset_restart_pc", dif.out_pc, RV);
    tick(3);

    // Random ready with occasional redirects near the imem edges and the address wrap.
    for (int c = 0; c < 1000; c++) begin
      dif.out_ready  = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 4))
        0:       a = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(0, 3));
        1:       a = 32'h0040_0FF0 | 32'($urandom_range(0, 3));
        2:       a = 32'h003F_FFF8;
        3:       a = 32'hFFFF_FFF8;
        default: a = $urandom;
      endcase
      redirect_addr = a;
      tick(1);
    end
    redirect_valid = 1'b0;
    dif.out_ready  = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the PC register / +4 adder / instruction memory trio.
- Owns the program counter and a synchronous-read instruction memory (1-cycle latency).
- Holds a small prefetch FIFO and presents {pc, instruction} to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of in-flight and buffered fetches; sits between the next-PC logic and decode.

Parameters:
- ADDR_W, 32: PC / address width.
- DATA_W, 32: instruction width.
- RESET_VECTOR, 32'h00400020: PC after reset.
- MEM_BASE, 32'h00400000: byte address of imem word 0.
- MEM_WORDS, 1024: imem depth in words.
- INIT_FILE, "add_test.v": $readmemh image.
- FIFO_DEPTH, 4: prefetch entries; power of 2, minimum 2.

Ports:
- clock, in, 1: sole clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high.
- redirect_valid, in, 1: load new PC this cycle.
- redirect_addr, in, ADDR_W: redirect target; bits [1:0] are ignored and forced to 0.
- out_valid, out, 1: FIFO head is valid.
- out_ready, in, 1: decode accepts the head.
- out_instr, out, DATA_W: head instruction.
- out_pc, out, ADDR_W: head byte address.
- out_fault, out, 1: head address was outside imem.
- fetch_count, out, 32: instructions accepted by decode.

Behaviour:
- Reset (clock edge with reset=1):
  - pc=RESET_VECTOR.
  - FIFO empty; out_valid=0; out_instr/out_pc/out_fault=0.
  - fetch_count=0.
  - In-flight read killed.
  - Reset overrides redirect and handshake.
- Issue: a read of pc is issued in cycle N when (occupancy + inflight) < FIFO_DEPTH and no redirect occurs. On issue, pc <= pc + 4, wrapping modulo 2^ADDR_W.
- Response: data for an issue in cycle N is written to the FIFO at the end of cycle N+1, tagged with its pc. At most one read is in flight.
- Earliest output: first out_valid=1 two cycles after reset deasserts.
- Sustained rate: one instruction per cycle when out_ready is held at 1.
- Address map:
  - idx = (pc - MEM_BASE) >> 2.
  - If idx >= MEM_WORDS (unsigned, which also covers pc < MEM_BASE): instruction=0 (nop) and fault=1 for that entry. pc still advances.
- Handshake:
  - Pop when out_valid & out_ready.
  - out_* are stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop with the FIFO full or empty is legal and leaves occupancy unchanged.
  - The head comes straight from FIFO storage; there is no bypass.
- Redirect (same cycle, highest priority after reset):
  - pc <= {redirect_addr[ADDR_W-1:2], 2'b00}.
  - FIFO flushed; out_valid=0 next cycle.
  - In-flight response discarded.
  - No issue in the redirect cycle.
  - A handshake completing in the redirect cycle still counts.
  - First redirected instruction appears two cycles later.
- Back-to-back redirects: the last one wins; each one flushes.
- fetch_count: +1 per completed handshake, wraps at 2^32.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output bubble_count (32), reset to 0. It increments each cycle with out_ready=1 && out_valid=0 && !reset, and wraps.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- fetch_pkg holds:
  - constants NOP_INSTR=0 and PC_STEP=4;
  - typedef fetch_entry_t {pc, instr, fault}.
- Sub-module imem_sync: synchronous ROM with ports clock, addr, rd_en, rdata, fault. It performs the base subtraction and the range check.
- fetch_unit instantiates imem_sync and contains the PC, credit logic and FIFO inline.

Test Plan:
- Reset then out_ready=1, image word k=k+1:
  - out_pc sequence is 0x00400020, 0x00400024, 0x00400028…
  - out_instr sequence is 9, 10, 11…
  - first out_valid is 2 cycles after reset drops.
- out_ready=0 for 10 cycles:
  - exactly FIFO_DEPTH=4 entries buffered; pc stops at 0x00400030;
  - head holds 0x00400020 / 9;
  - on out_ready=1, four entries drain in order with no gap or duplicate.
- redirect_valid pulse with redirect_addr=0x00400103 while FIFO has 3 entries:
  - out_valid=0 next cycle;
  - next out_pc=0x00400100, out_instr = word 64 (value 65);
  - no stale entries appear.
- redirect_addr=0x00500000:
  - out_instr=0, out_fault=1;
  - next out_pc=0x00500004, still faulting.
- Reset asserted mid-stream with FIFO full and a read in flight:
  - out_valid=0 and fetch_count=0 next cycle;
  - restart from 0x00400020.
- Random out_ready (50%) over 1000 cycles:
  - fetch_count equals the handshake count;
  - out_pc is strictly +4 per accepted instruction;
  - with FETCH_PERF_EN, bubble_count equals the scoreboard bubble count.
